// File: rtl/bus_dtack_generator.sv
// 68000 bus-cycle responder: qualifies CPU strobes, times per-region wait states,
// forwards external acknowledges and raises BERR on timeout or unmapped access.
module bus_dtack_generator #(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 2,
    parameter int unsigned VGA_WAIT = 3,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic Clk,
    input  logic Reset_L,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic DramSelect_H,
    input  logic IOSelect_H,
    input  logic CanBusSelect_H,
    input  logic vga_select_H,
    input  logic DramDtack_L,
    input  logic CanBusDtack_L,
    output logic DtackOut_L,
    output logic BERR_L,
    output logic CycleActive_H,
    output logic BerrSticky_H
);

    localparam int unsigned CntW = 8;

    localparam logic [2:0] Idle    = 3'd0;
    localparam logic [2:0] IntWait = 3'd1;
    localparam logic [2:0] ExtWait = 3'd2;
    localparam logic [2:0] Ack     = 3'd3;
    localparam logic [2:0] Error   = 3'd4;

    localparam logic [1:0] SrcNone = 2'd0;
    localparam logic [1:0] SrcDram = 2'd1;
    localparam logic [1:0] SrcCan  = 2'd2;

    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    logic [2:0]      state, stateNext;
    logic [CntW-1:0] waitCnt, waitNext;
    logic [CntW-1:0] toCnt, toNext;
    logic [1:0]      extSrc, srcNext;

    logic            strobe;
    logic            extAck;
    logic            intHit;
    logic [CntW-1:0] intWait;
    logic [CntW-1:0] waitDec;
    logic [CntW-1:0] toInc;

    // Region decode in priority order ROM > RAM > DRAM > IO > CAN > VGA
    always_comb begin
        intHit  = 1'b0;
        intWait = '0;
        srcNext = SrcNone;
        if (OnChipRomSelect_H) begin
            intHit  = 1'b1;
            intWait = CntW'(ROM_WAIT);
        end else if (OnChipRamSelect_H) begin
            intHit  = 1'b1;
            intWait = CntW'(RAM_WAIT);
        end else if (DramSelect_H) begin
            srcNext = SrcDram;
        end else if (IOSelect_H) begin
            intHit  = 1'b1;
            intWait = CntW'(IO_WAIT);
        end else if (CanBusSelect_H) begin
            srcNext = SrcCan;
        end else if (vga_select_H) begin
            intHit  = 1'b1;
            intWait = CntW'(VGA_WAIT);
        end
    end

    // Next-state and counter logic
    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        toNext    = toCnt;
        strobe    = !AS_L && (!UDS_L || !LDS_L);
        extAck    = ((extSrc == SrcDram) && !DramDtack_L) ||
                    ((extSrc == SrcCan)  && !CanBusDtack_L);
        waitDec   = waitCnt - CntW'(1);
        toInc     = toCnt + CntW'(1);

        case (state)
            Idle: begin
                if (strobe) begin
                    toNext = '0;
                    if (intHit) begin
                        waitNext  = intWait;
                        stateNext = (intWait == '0) ? Ack : IntWait;
                    end else begin
                        stateNext = ExtWait;
                    end
                end
            end
            IntWait: begin
                toNext = toInc;
                if (AS_L)                     stateNext = Idle;
                else if (waitDec == '0)       stateNext = Ack;
                else if (toInc == TimeoutCnt) stateNext = Error;
                if (!AS_L) waitNext = waitDec;
            end
            ExtWait: begin
                toNext = toInc;
                if (AS_L)                     stateNext = Idle;
                else if (extAck)              stateNext = Ack;
                else if (toInc == TimeoutCnt) stateNext = Error;
            end
            Ack, Error: begin
                if (AS_L) stateNext = Idle;
            end
            default: stateNext = Idle;
        endcase
    end

    // State, counters and registered outputs; reset is synchronous
    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            state         <= Idle;
            waitCnt       <= '0;
            toCnt         <= '0;
            extSrc        <= SrcNone;
            DtackOut_L    <= 1'b1;
            BERR_L        <= 1'b1;
            CycleActive_H <= 1'b0;
            BerrSticky_H  <= 1'b0;
        end else begin
            state         <= stateNext;
            waitCnt       <= waitNext;
            toCnt         <= toNext;
            if (state == Idle) extSrc <= srcNext;
            DtackOut_L    <= (stateNext != Ack);
            BERR_L        <= (stateNext != Error);
            CycleActive_H <= (stateNext != Idle);
            BerrSticky_H  <= BerrSticky_H || (stateNext == Error);
        end
    end

endmodule

// File: doc/bus_dtack_generator.md
# bus_dtack_generator

- Responder half of the 68000 bus cycle. Sits between the CPU and the address decoder's region selects.
- Qualifies each CPU access with AS_L/UDS_L/LDS_L and times the per-region wait states.
- For DRAM and CAN bus accesses, which end their own cycles, forwards the external acknowledge.
- Drives the single DtackOut_L, or BERR_L on timeout/unmapped access, back to the CPU.

## Interface

Parameters:
- ROM_WAIT, default 1: wait clocks for the on-chip ROM region.
- RAM_WAIT, default 1: wait clocks for the on-chip RAM region.
- IO_WAIT, default 2: wait clocks for the IO region.
- VGA_WAIT, default 3: wait clocks for the VGA region.
- TIMEOUT, default 64: clocks from cycle start to bus error. Must exceed every *_WAIT; range 2..255. Counter width is 8 bits.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_L  in  1  one clock; reset is synchronous and active-low.
- AS_L  in  1  CPU address strobe, active low.
- UDS_L, LDS_L  in  1 each  CPU data strobes, active low.
- OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H, CanBusSelect_H, vga_select_H  in  1 each  decoder region selects.
- DramDtack_L  in  1  DRAM controller acknowledge, active low.
- CanBusDtack_L  in  1  CAN controller acknowledge, active low.
- DtackOut_L  out  1  acknowledge to CPU, active low, registered.
- BERR_L  out  1  bus error to CPU, active low, registered.
- CycleActive_H  out  1  high while a cycle is being serviced, registered.
- BerrSticky_H  out  1  set on any bus error; cleared only by reset.

## Operation

States: IDLE, INT_WAIT, EXT_WAIT, ACK, ERROR.

**IDLE**
- Leaves only when AS_L=0 and (UDS_L=0 or LDS_L=0) are sampled together.
- Region priority: ROM > RAM > DRAM > IO > CAN > VGA. The highest active select wins; lower selects are ignored.
- ROM/RAM/IO/VGA: load the wait counter with that region's *_WAIT. If the value is 0, go directly to ACK; otherwise go to INT_WAIT.
- DRAM/CAN: go to EXT_WAIT and latch which acknowledge input to watch.
- No select active: go to EXT_WAIT with no acknowledge source, so the access can only time out.
- Timeout counter clears to 0 on leaving IDLE.

**INT_WAIT**
- Decrement the wait counter each clock. When it reaches 0, go to ACK.

**EXT_WAIT**
- When the latched source's acknowledge is sampled low, go to ACK.
- The other source's acknowledge is ignored.

**INT_WAIT and EXT_WAIT (common rules)**
- Timeout counter increments each clock.
- When the timeout count reaches TIMEOUT, go to ERROR.
- If acknowledge and timeout occur on the same edge, acknowledge wins.
- AS_L sampled high (aborted cycle): return to IDLE with no DTACK and no BERR.

**ACK**
- DtackOut_L=0. Hold until AS_L is sampled high, then go to IDLE.

**ERROR**
- BERR_L=0 and BerrSticky_H is set. Hold until AS_L is sampled high, then go to IDLE.

**Outputs**
- CycleActive_H=1 in every state except IDLE.
- DtackOut_L and BERR_L are never low at the same time.
- Select inputs are sampled only in IDLE; changes during a cycle are ignored.
- Back-to-back cycles: AS_L must be sampled high at least once (IDLE entered) before a new cycle starts.

## Timing

**Reset**
- Reset_L low at an edge forces IDLE at that edge, even mid-cycle.
- Output values after that edge: DtackOut_L=1, BERR_L=1, CycleActive_H=0, BerrSticky_H=0; both counters 0.

**Internal regions**
- E0 = the edge at which IDLE samples a valid strobe.
- DtackOut_L goes low after edge E0+W, where W is the region's wait value. W=0 gives low after E0.

**External regions**
- DtackOut_L goes low after the first edge E1 > E0 at which the latched acknowledge is sampled low.

**Timeout**
- BERR_L goes low after edge E0+TIMEOUT if no acknowledge has arrived.

**Release**
- DtackOut_L or BERR_L returns high after the first edge at which AS_L is sampled high.
- Worst-case extra hold after CPU strobe release: one clock.

## Test plan

1. IO read: assert IOSelect_H, AS_L=0, LDS_L=0 at E0 → DtackOut_L low after E0+2. Release AS_L → DtackOut_L high one edge later; BERR_L stays 1 throughout.
2. DRAM write: DramSelect_H=1, DramDtack_L driven low at E0+7 → DtackOut_L low after E0+7. Pulse CanBusDtack_L low at E0+3 → no effect.
3. Unmapped access: no select, AS_L held low → BERR_L low after E0+64 and BerrSticky_H=1. Release AS_L → IDLE, BERR_L=1, BerrSticky_H remains 1.
4. Priority: ROM and VGA selects together → DtackOut_L low after E0+1 (ROM timing), not E0+3.
5. Abort/reset: AS_L raised at E0+1 during a VGA wait → no DTACK and IDLE at the next edge. Separately, Reset_L low mid-EXT_WAIT → all outputs at reset values after that edge.
6. Collision: DramDtack_L first sampled low exactly at E0+64 → DtackOut_L=0, BERR_L=1.
